interboard_sender: RTL and testbench

INTERBOARD_SENDER -- requirements
Module: interboard_sender

---
 rtl/interboard_sender_pkg.sv | 56 +++++
 rtl/interboard_sender_msg_fifo.sv | 61 ++++++
 rtl/interboard_sender.sv | 161 ++++++++++++++++
 tb/tb_interboard_sender.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/interboard_sender_pkg.sv
// Shared interboard definitions: message layout, beat format and sender FSM states.
package interboard_sender_pkg;

  localparam int MSG_W    = 9;
  localparam int BEAT_W   = 6;
  localparam int TYPE_W   = 3;
  localparam int NUMBER_W = 5;

  // Beat format bit positions.
  localparam int BEAT_SEL_BIT   = 5;  // 0 = header beat, 1 = number beat
  localparam int BEAT0_EN_BIT   = 4;
  localparam int BEAT0_TYPE_LSB = 0;
  localparam int BEAT1_NUM_LSB  = 0;

  // msg_type encodings carried in the header beat.
  typedef enum logic [TYPE_W-1:0] {
    MSG_TYPE_0 = 3'd0,
    MSG_TYPE_1 = 3'd1,
    MSG_TYPE_2 = 3'd2,
    MSG_TYPE_3 = 3'd3,
    MSG_TYPE_4 = 3'd4,
    MSG_TYPE_5 = 3'd5,
    MSG_TYPE_6 = 3'd6,
    MSG_TYPE_7 = 3'd7
  } msg_type_t;

  // One queued message; packing order gives {en, msg_type, number}.
  typedef struct packed {
    logic                en;
    logic [TYPE_W-1:0]   msg_type;
    logic [NUMBER_W-1:0] number;
  } msg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_WAIT_ACK_H,
    ST_WAIT_ACK_L
  } sender_state_t;

  // Build the 6-bit beat for a message: header (idx 0) or number (idx 1).
  function automatic logic [BEAT_W-1:0] make_beat(msg_t m, logic beat_idx);
    logic [BEAT_W-1:0] b;
    b = '0;
    if (beat_idx) begin
      b[BEAT_SEL_BIT]                             = 1'b1;
      b[BEAT1_NUM_LSB +: NUMBER_W]                = m.number;
    end else begin
      b[BEAT0_EN_BIT]                             = m.en;
      b[BEAT0_TYPE_LSB +: TYPE_W]                 = m.msg_type;
    end
    return b;
  endfunction

endpackage

// File: rtl/interboard_sender_msg_fifo.sv
// Synchronous show-ahead FIFO holding messages waiting to be sent.
import interboard_sender_pkg::*;

module msg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = MSG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Fullness is judged on the current count, before any same-cycle pop.
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write port.
  // NOTE: the array has no reset; stale entries are unreachable once the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; push and pop together leave the count unchanged.
  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/interboard_sender.sv
// Sends queued 9-bit messages to the peer board as two 6-bit beats over a
// four-phase Request/Ack handshake, with per-phase timeout.
import interboard_sender_pkg::*;

module interboard_sender #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              interboard_rst,
  input  logic              transmit,
  input  logic              ctrl_en,
  input  logic [2:0]        ctrl_msg_type,
  input  logic [4:0]        ctrl_number,
  input  logic              Ack_in,
  output logic              Request_out,
  output logic [5:0]        inter_data_out,
  output logic              inter_ready,
  output logic              tx_done,
  output logic              tx_error,
  output logic              tx_overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  sender_state_t    state;
  sender_state_t    state_next;
  logic             clear;
  logic [1:0]       ack_sync;
  logic             ack_s;
  msg_t             push_msg;
  logic [MSG_W-1:0] fifo_pop_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  msg_t             msg_q;
  logic             beat_idx;
  logic [TMR_W-1:0] ack_timer;
  logic             timer_clr;
  logic             timer_expired;
  logic             done_next;
  logic             error_next;

  // Either reset source returns the whole block to its power-up state.
  assign clear    = rst | interboard_rst;
  assign ack_s    = ack_sync[1];
  assign push_msg = '{en: ctrl_en, msg_type: ctrl_msg_type, number: ctrl_number};

  assign inter_ready   = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign timer_expired = (ack_timer == TMR_W'(ACK_TIMEOUT - 1));

  msg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MSG_W)
  ) u_msg_fifo (
    .clk       (clk),
    .rst       (clear),
    .push      (transmit),
    .push_data (push_msg),
    .pop       (state == ST_LOAD),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Two-flop synchroniser for the asynchronous acknowledge.
  always_ff @(posedge clk) begin
    if (clear) ack_sync <= '0;
    else       ack_sync <= {ack_sync[0], Ack_in};
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (clear) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; ack_s is only looked at in the two wait states.
  // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_next = state;
    timer_clr  = 1'b0;
    done_next  = 1'b0;
    error_next = 1'b0;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_SETUP;
      ST_SETUP: begin
        state_next = ST_WAIT_ACK_H;
        timer_clr  = 1'b1;
      end
      ST_WAIT_ACK_H: begin
        if (ack_s) begin
          state_next = ST_WAIT_ACK_L;
          timer_clr  = 1'b1;
        end else if (timer_expired) begin
          state_next = ST_IDLE;
          error_next = 1'b1;
        end
      end
      ST_WAIT_ACK_L: begin
        if (!ack_s) begin
          if (beat_idx) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_SETUP;
          end
        end else if (timer_expired) begin
          state_next = ST_IDLE;
          error_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Beat datapath: latch the popped message and load each beat as SETUP is entered.
  always_ff @(posedge clk) begin
    if (clear) begin
      msg_q          <= '0;
      beat_idx       <= 1'b0;
      inter_data_out <= '0;
    end else if (state == ST_LOAD) begin
      msg_q          <= msg_t'(fifo_pop_data);
      beat_idx       <= 1'b0;
      inter_data_out <= make_beat(msg_t'(fifo_pop_data), 1'b0);
    end else if (state == ST_WAIT_ACK_L && state_next == ST_SETUP) begin
      beat_idx       <= 1'b1;
      inter_data_out <= make_beat(msg_q, 1'b1);
    end
  end

  // Handshake timeout: counts cycles spent in the current wait state.
  always_ff @(posedge clk) begin
    if (clear || timer_clr) begin
      ack_timer <= '0;
    end else if (state == ST_WAIT_ACK_H || state == ST_WAIT_ACK_L) begin
      ack_timer <= ack_timer + 1'b1;
    end
  end

  // Registered request and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (clear) begin
      Request_out <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      Request_out <= (state_next == ST_WAIT_ACK_H);
      tx_done     <= done_next;
      tx_error    <= error_next;
      tx_overflow <= transmit && fifo_full;
    end
  end

endmodule

// File: tb/tb_interboard_sender.sv
// Self-checking bench for interboard_sender: beat-format table, overflow,
// timeout, soft reset, ack glitch, and randomized traffic against a message scoreboard.
module tb_interboard_sender;

  localparam int FIFO_DEPTH  = 4;
  localparam int ACK_TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rst, interboard_rst, transmit, ctrl_en, Ack_in;
  logic [2:0] ctrl_msg_type;
  logic [4:0] ctrl_number;
  logic       Request_out, inter_ready, tx_done, tx_error, tx_overflow;
  logic [5:0] inter_data_out;

  always #10 clk = ~clk;

  interboard_sender #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .transmit       (transmit),
    .ctrl_en        (ctrl_en),
    .ctrl_msg_type  (ctrl_msg_type),
    .ctrl_number    (ctrl_number),
    .Ack_in         (Ack_in),
    .Request_out    (Request_out),
    .inter_data_out (inter_data_out),
    .inter_ready    (inter_ready),
    .tx_done        (tx_done),
    .tx_error       (tx_error),
    .tx_overflow    (tx_overflow)
  );

  typedef struct {
    logic       en;
    logic [2:0] mtype;
    logic [4:0] num;
    logic [5:0] b0;
    logic [5:0] b1;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Monitor / scoreboard state
  logic       req_prev = 1'b0;
  int         req_run = 0, last_run = 0;
  int         done_cnt = 0, err_cnt = 0, ovf_cnt = 0, rise_cnt = 0;
  logic [8:0] exp_q[$];
  logic [8:0] cur_msg = '0;
  logic [5:0] last_b0 = '0, last_b1 = '0;

  // Peer model state
  bit peer_en = 0, peer_rand = 0;
  int peer_cnt = 0, peer_delay = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Expected beats from the message fields with plain arithmetic.
  function automatic logic [5:0] ref_beat(input logic [8:0] m, input int idx);
    int v;
    if (idx == 0) v = (m[8] ? 16 : 0) + int'(m[7:5]);
    else          v = 32 + int'(m[4:0]);
    return v[5:0];
  endfunction

  // Advance one cycle, sample outputs 1 ns after the edge, then let the peer react.
  task automatic tick();
    @(posedge clk);
    #1;
    if (tx_done === 1'b1)     done_cnt++;
    if (tx_error === 1'b1)    err_cnt++;
    if (tx_overflow === 1'b1) ovf_cnt++;
    if (Request_out === 1'b1) begin
      if (req_prev !== 1'b1) begin
        rise_cnt++;
        req_run = 0;
        if (inter_data_out[5] == 1'b0) begin
          last_b0 = inter_data_out;
          if (exp_q.size() == 0) begin
            check("unexpected_beat0", 0, 1);
          end else begin
            cur_msg = exp_q.pop_front();
            check("beat0", inter_data_out, ref_beat(cur_msg, 0));
          end
        end else begin
          last_b1 = inter_data_out;
          check("beat1", inter_data_out, ref_beat(cur_msg, 1));
        end
      end
      req_run++;
    end else if (req_prev === 1'b1) begin
      last_run = req_run;
    end
    req_prev = Request_out;
    if (peer_en) begin
      if (Request_out !== Ack_in) begin
        if (peer_cnt >= peer_delay) begin
          Ack_in   = Request_out;
          peer_cnt = 0;
          if (peer_rand) peer_delay = $urandom_range(0, 3);
        end else begin
          peer_cnt++;
        end
      end else begin
        peer_cnt = 0;
      end
    end
  endtask

  task automatic send(input logic en, input logic [2:0] t, input logic [4:0] n, input bit accept);
    transmit      = 1'b1;
    ctrl_en       = en;
    ctrl_msg_type = t;
    ctrl_number   = n;
    if (accept) exp_q.push_back({en, t, n});
    tick();
    transmit = 1'b0;
  endtask

  task automatic wait_req(input logic level, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (Request_out === level) begin
        ok = 1;
        return;
      end
      tick();
    end
    ok = (Request_out === level);
  endtask

  task automatic wait_done(input int start, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      if (done_cnt > start) begin
        ok = 1;
        return;
      end
      tick();
    end
    ok = (done_cnt > start);
  endtask

  initial begin
    vec_t tbl[5];
    bit   ok;
    int   d0, e0, o0, r0, sent;

    tbl[0] = '{en: 1'b1, mtype: 3'd2, num: 5'd17, b0: 6'b010010, b1: 6'b110001};
    tbl[1] = '{en: 1'b0, mtype: 3'd0, num: 5'd0,  b0: 6'b000000, b1: 6'b100000};
    tbl[2] = '{en: 1'b1, mtype: 3'd7, num: 5'd31, b0: 6'b010111, b1: 6'b111111};
    tbl[3] = '{en: 1'b0, mtype: 3'd5, num: 5'd10, b0: 6'b000101, b1: 6'b101010};
    tbl[4] = '{en: 1'b1, mtype: 3'd0, num: 5'd1,  b0: 6'b010000, b1: 6'b100001};

    rst = 1'b1; interboard_rst = 1'b0; transmit = 1'b0; Ack_in = 1'b0;
    ctrl_en = 1'b0; ctrl_msg_type = '0; ctrl_number = '0;

    // Reset state
    repeat (3) tick();
    check("rst_request", Request_out, 0);
    check("rst_data", inter_data_out, 0);
    check("rst_ready", inter_ready, 1);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    check("rst_overflow", tx_overflow, 0);
    rst = 1'b0;
    tick();

    // Beat format table, peer acking 5 cycles after each edge
    peer_en = 1; peer_rand = 0; peer_delay = 5;
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      send(tbl[i].en, tbl[i].mtype, tbl[i].num, 1);
      wait_done(d0, 200, ok);
      check($sformatf("tbl%0d_done_wait", i), ok, 1);
      repeat (5) tick();
      check($sformatf("tbl%0d_b0", i), last_b0, tbl[i].b0);
      check($sformatf("tbl%0d_b1", i), last_b1, tbl[i].b1);
      check($sformatf("tbl%0d_done_once", i), done_cnt - d0, 1);
    end

    // Overflow: one message stuck waiting for ack, then five back-to-back pulses
    peer_en = 0; Ack_in = 1'b0;
    send(1'b0, 3'd6, 5'd9, 1);
    wait_req(1'b1, 50, ok);
    check("ovf_first_req", ok, 1);
    o0 = ovf_cnt;
    for (int i = 0; i < 5; i++) begin
      send(1'(i), 3'(i + 1), 5'(i * 3 + 4), i < 4);
      if (i == 2) check("ready_after_3", inter_ready, 1);
      if (i == 3) check("ready_after_4", inter_ready, 0);
      if (i == 4) check("overflow_pulse", tx_overflow, 1);
    end
    tick();
    check("overflow_count", ovf_cnt - o0, 1);

    // Timeout with Ack held low, then next queued message starts
    e0 = err_cnt;
    wait_req(1'b0, 60, ok);
    check("timeout_drop", ok, 1);
    check("timeout_len", last_run, ACK_TIMEOUT);
    check("timeout_error", tx_error, 1);
    wait_req(1'b1, 20, ok);
    check("next_msg_start", ok, 1);
    check("timeout_error_once", err_cnt - e0, 1);

    // Soft reset while waiting for Ack high
    d0 = done_cnt; e0 = err_cnt;
    interboard_rst = 1'b1;
    tick();
    interboard_rst = 1'b0;
    check("soft_rst_request", Request_out, 0);
    check("soft_rst_ready", inter_ready, 1);
    check("soft_rst_data", inter_data_out, 0);
    exp_q.delete();
    r0 = rise_cnt;
    repeat (30) tick();
    check("soft_rst_fifo_empty", rise_cnt - r0, 0);
    check("soft_rst_no_done", done_cnt - d0, 0);
    check("soft_rst_no_error", err_cnt - e0, 0);

    // Ack glitch landing on the SETUP cycle is ignored
    d0 = done_cnt;
    send(1'b1, 3'd3, 5'd21, 1);
    Ack_in = 1'b1;
    tick();
    Ack_in = 1'b0;
    wait_req(1'b1, 20, ok);
    check("glitch_req_rises", ok, 1);
    repeat (8) tick();
    check("glitch_req_held", Request_out, 1);
    peer_en = 1; peer_delay = 2;
    wait_done(d0, 200, ok);
    check("glitch_done", ok, 1);

    // Randomized traffic against the scoreboard
    peer_rand = 1; peer_delay = 1;
    d0 = done_cnt; e0 = err_cnt; o0 = ovf_cnt; sent = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 2) == 0 && exp_q.size() < FIFO_DEPTH) begin
        check("rnd_ready", inter_ready, 1);
        send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 1);
        sent++;
      end else begin
        tick();
      end
    end
    for (int c = 0; c < 2000 && (done_cnt - d0) < sent; c++) tick();
    repeat (5) tick();
    check("rnd_done", done_cnt - d0, sent);
    check("rnd_error", err_cnt - e0, 0);
    check("rnd_overflow", ovf_cnt - o0, 0);
    check("rnd_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
